// File: rtl/thr_pkg.sv
// Shared constants and types for the serial threshold loader.
// The PAR state exists only when THR_PARITY_EN is defined.
package thr_pkg;

  localparam int W_DEF = 12;
  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef THR_PARITY_EN
    , PAR
`endif
  } state_t;

  typedef logic signed [W_DEF-1:0] thr_word_t;

endpackage

// File: rtl/shreg_in.sv
// W-bit MSB-first serial-in shift register with synchronous clear.
module shreg_in #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (clear) q <= '0;
    else if (shift) q <= {q[W-2:0], din};
  end

endmodule

// File: rtl/thr_loader.sv
// Serial loader of N signed W-bit threshold words, MSB first, gated by enable.
// Optional even-parity bit per word when THR_PARITY_EN is defined.
module thr_loader
  import thr_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                din,
  output logic signed [W-1:0] soglia [N],
  output logic [N-1:0]        soglia_valid,
  output logic                word_done,
  output logic                frame_done,
  output logic                frame_err
`ifdef THR_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int CW  = $clog2(W);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;

  state_t         state, state_nxt;
  logic [CW-1:0]  bit_cnt;
  logic [CHW-1:0] ch;
  logic [W-1:0]   shreg;
  logic [W-1:0]   word;
  logic           shift, clear, commit, abort, par_fail;
  logic           last_bit, last_ch;

  assign last_bit = (bit_cnt == CW'(W - 1));
  assign last_ch  = (ch == CHW'(N - 1));

  shreg_in #(.W(W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .shift (shift),
    .din   (din),
    .q     (shreg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Without parity the W-th bit is still on din when the word commits.
  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    clear     = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    par_fail  = 1'b0;
    word      = {shreg[W-2:0], din};
    case (state)
      IDLE: begin
        if (enable) begin
          shift     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!enable) begin
          abort     = 1'b1;
          clear     = 1'b1;
          state_nxt = IDLE;
        end else if (last_bit) begin
`ifdef THR_PARITY_EN
          shift     = 1'b1;
          state_nxt = PAR;
`else
          commit    = 1'b1;
          clear     = 1'b1;
          state_nxt = IDLE;
`endif
        end else begin
          shift = 1'b1;
        end
      end
`ifdef THR_PARITY_EN
      PAR: begin
        word      = shreg;
        clear     = 1'b1;
        state_nxt = IDLE;
        if (!enable)            abort    = 1'b1;
        else if (^shreg ^ din)  par_fail = 1'b1;
        else                    commit   = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      ch      <= '0;
    end else begin
      if (clear || (shift && last_bit)) bit_cnt <= '0;
      else if (shift)                   bit_cnt <= bit_cnt + 1'b1;

      if (abort)       ch <= '0;
      else if (commit) ch <= last_ch ? '0 : ch + 1'b1;
    end
  end

  // Valid flags are sticky across frame wraps; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) soglia[i] <= '0;
      soglia_valid <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (commit && ch == CHW'(i)) begin
          soglia[i]       <= word;
          soglia_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_done  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_done  <= commit;
      frame_done <= commit && last_ch;
      frame_err  <= abort;
    end
  end

`ifdef THR_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= par_fail;
  end
`endif

endmodule

// File: tb/tb_thr_loader.sv
// Scoreboard bench for thr_loader: a 4-channel and a 1-channel instance share one serial stream.
module tb_thr_loader;
  import thr_pkg::*;

  localparam int W = 12;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst, enable, din;

  logic signed [W-1:0] soglia [N];
  logic [N-1:0]        soglia_valid;
  logic                word_done, frame_done, frame_err;
  logic signed [W-1:0] soglia1 [1];
  logic [0:0]          soglia_valid1;
  logic                word_done1, frame_done1, frame_err1;
`ifdef THR_PARITY_EN
  logic                parity_err, parity_err1;
`endif

  always #5 clk = ~clk;

  thr_loader #(.W(W), .N(N)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .din          (din),
    .soglia       (soglia),
    .soglia_valid (soglia_valid),
    .word_done    (word_done),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
`ifdef THR_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  thr_loader #(.W(W), .N(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .din          (din),
    .soglia       (soglia1),
    .soglia_valid (soglia_valid1),
    .word_done    (word_done1),
    .frame_done   (frame_done1),
    .frame_err    (frame_err1)
`ifdef THR_PARITY_EN
    ,
    .parity_err   (parity_err1)
`endif
  );

  typedef struct {
    int        ch;
    thr_word_t word;
    logic      last;
  } exp_t;

  exp_t      exp_q[$];
  thr_word_t exp1_q[$];
  exp_t      mon_e;
  thr_word_t mon_w1;
  int        pending_err;
  int        pending_perr;
  thr_word_t exp_soglia [N];
  logic [N-1:0] exp_valid;
  thr_word_t exp1_soglia;
  logic      exp1_valid;
  int        exp_ch;
  int        n_checks = 0;
  int        n_pass = 0;
  logic      wd_prev = 1'b0;
  logic      fe_prev = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_soglia[i] = '0;
    exp_valid    = '0;
    exp1_soglia  = '0;
    exp1_valid   = 1'b0;
    exp_ch       = 0;
    pending_err  = 0;
    pending_perr = 0;
    exp_q.delete();
    exp1_q.delete();
  endtask

  // Sends one full word; expectations are queued before the bits go out.
  task automatic apply_stimulus(input thr_word_t w, input bit par_ok = 1'b1);
`ifdef THR_PARITY_EN
    if (!par_ok) pending_perr++;
`endif
    if (par_ok) begin
      exp_q.push_back('{exp_ch, w, (exp_ch == N - 1)});
      exp_soglia[exp_ch] = w;
      exp_valid[exp_ch]  = 1'b1;
      exp_ch             = (exp_ch + 1) % N;
      exp1_q.push_back(w);
      exp1_soglia = w;
      exp1_valid  = 1'b1;
    end
    for (int i = W - 1; i >= 0; i--) begin
      enable = 1'b1;
      din    = w[i];
      @(posedge clk);
      #1;
    end
`ifdef THR_PARITY_EN
    enable = 1'b1;
    din    = par_ok ? ^w : ~^w;
    @(posedge clk);
    #1;
`endif
    enable = 1'b0;
    din    = 1'b0;
  endtask

  task automatic send_partial(input int nbits, input thr_word_t w);
    for (int i = W - 1; i > W - 1 - nbits; i--) begin
      enable = 1'b1;
      din    = w[i];
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    din    = 1'b0;
    pending_err++;
    exp_ch = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++)
      check_output($sformatf("%s_soglia%0d", tag, i), soglia[i], exp_soglia[i]);
    check_output({tag, "_valid"}, soglia_valid, exp_valid);
    check_output({tag, "_soglia_n1"}, soglia1[0], exp1_soglia);
    check_output({tag, "_valid_n1"}, soglia_valid1, exp1_valid);
  endtask

  task automatic check_pulses_zero(input string tag);
    check_output({tag, "_pulses"}, {word_done, frame_done, frame_err, word_done1, frame_done1, frame_err1}, 6'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (rst) begin
      wd_prev = 1'b0;
      fe_prev = 1'b0;
    end else begin
      if (word_done) begin
        check_output("word_done_width", wd_prev, 1'b0);
        check_output("word_done_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_output($sformatf("sb_soglia%0d", mon_e.ch), soglia[mon_e.ch], mon_e.word);
          check_output("sb_frame_done", frame_done, mon_e.last);
          check_output("sb_valid_bit", soglia_valid[mon_e.ch], 1'b1);
        end
      end else if (frame_done) begin
        check_output("frame_done_without_word", frame_done, 1'b0);
      end
      if (word_done1) begin
        check_output("word_done_n1_expected", exp1_q.size() != 0, 1'b1);
        if (exp1_q.size() != 0) begin
          mon_w1 = exp1_q.pop_front();
          check_output("sb_soglia_n1", soglia1[0], mon_w1);
          check_output("sb_frame_done_n1", frame_done1, 1'b1);
        end
      end
      if (frame_err || frame_err1) begin
        check_output("frame_err_width", fe_prev, 1'b0);
        check_output("frame_err_expected", pending_err > 0, 1'b1);
        check_output("frame_err_n1", frame_err1, frame_err);
        if (pending_err > 0) pending_err--;
      end
`ifdef THR_PARITY_EN
      if (parity_err || parity_err1) begin
        check_output("parity_err_expected", pending_perr > 0, 1'b1);
        check_output("parity_err_n1", parity_err1, parity_err);
        if (pending_perr > 0) pending_perr--;
      end
`endif
      wd_prev = word_done;
      fe_prev = frame_err;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    din    = 1'b0;
    clear_model();
    #12;
    check_all("reset");
    check_pulses_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full frame back to back; first word also exercises the single-channel instance.
    apply_stimulus(12'h65D);
    apply_stimulus(12'h9A2);
    apply_stimulus(12'h000);
    apply_stimulus(12'h7FF);
    idle(2);
    check_all("frame");
    check_output("frame_drained", exp_q.size(), 0);

    // Abort partway through the channel-1 word.
    apply_stimulus(12'h123);
    send_partial(5, 12'h456);
    idle(2);
    check_all("abort");
    check_output("abort_err_seen", pending_err, 0);
    apply_stimulus(12'h456);
    idle(2);
    check_all("after_abort");

    // Inter-word gap between channel 0 and channel 1.
    idle(3);
    apply_stimulus(12'h789);
    idle(2);
    check_all("gap");
    check_output("gap_no_err", pending_err, 0);

    // Asynchronous reset seven bits into a word.
    for (int i = W - 1; i > W - 8; i--) begin
      enable = 1'b1;
      din    = i[0];
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    check_all("midreset");
    check_pulses_zero("midreset");
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef THR_PARITY_EN
    apply_stimulus(12'h65D, 1'b0);
    idle(2);
    check_all("parity_bad");
    check_output("parity_err_seen", pending_perr, 0);
    apply_stimulus(12'h65D, 1'b1);
    idle(2);
    check_all("parity_good");
`endif

    apply_stimulus(12'h123);
    idle(2);
    check_all("post_reset");
    check_output("final_queue", exp_q.size() + exp1_q.size(), 0);
    check_output("final_err", pending_err + pending_perr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/thr_loader.md
THR_LOADER -- requirements
Module: thr_loader

Interface
REQ-001 Parameter W, default 12: bit width of each signed threshold word.
REQ-002 Parameter N, default 4: number of threshold channels loaded per frame; N >= 1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  serial data qualifier; din is sampled only when enable=1.
REQ-006 din  input  1  serial data, MSB first.
REQ-007 soglia  output  N x W signed  per-channel threshold registers.
REQ-008 soglia_valid  output  N  per-channel flag: soglia[i] holds a complete word.
REQ-009 word_done  output  1  one-cycle pulse: a word was committed.
REQ-010 frame_done  output  1  one-cycle pulse: channel N-1 was committed.
REQ-011 frame_err  output  1  one-cycle pulse: word aborted by enable deassertion.

Function
REQ-012 The block SHALL keep a bit counter (0..W-1) and a channel index (0..N-1).
REQ-013 FSM states: IDLE (bit counter 0, no word in progress), SHIFT (word in progress), PAR (parity bit pending, only with THR_PARITY_EN).
REQ-014 IDLE -> SHIFT on the first edge with enable=1; din is shifted in, and the bit counter becomes 1.
REQ-015 In SHIFT, each edge with enable=1 shifts din into the LSB of the shift register and increments the bit counter.
REQ-016 On the edge sampling the W-th bit, soglia[ch] SHALL load the full word {shreg[W-2:0], din}.
  - In the same edge: soglia_valid[ch] is set, word_done pulses, and the bit counter clears.
  - Result is visible one cycle after the last bit is presented.
REQ-017 After a commit, ch increments; on committing ch=N-1, frame_done pulses together with word_done and ch wraps to 0.
REQ-018 Enable low in IDLE is an inter-word gap: ch is held and there is no error.
REQ-019 Enable low in SHIFT or PAR is an abort:
  - frame_err pulses and the partial word is discarded.
  - soglia and soglia_valid are unchanged.
  - The bit counter clears, ch returns to 0, and the FSM enters IDLE.
REQ-020 Words received after a wrap SHALL overwrite channels from 0; previously valid flags stay set.
REQ-021 Pulses SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-022 On rst=1, the following SHALL clear immediately, including mid-word: soglia (all zero), soglia_valid, word_done, frame_done, frame_err, the shift register, the bit counter and ch; the FSM enters IDLE.
REQ-023 After rst deasserts, the first enable=1 edge SHALL be treated as bit W-1 of channel 0.

Configuration
REQ-024 Macro THR_PARITY_EN:
  - Defined: after the W-th bit the FSM enters PAR and samples one even-parity bit (XOR of the word and the parity bit = 0).
    - Commit occurs on the parity edge.
    - On mismatch, the word is discarded, the output parity_err (1 bit) pulses, ch is unchanged, and the FSM returns to IDLE.
  - Undefined: no PAR state, no parity_err port, and commit occurs on the W-th bit.

Structure
REQ-025 A shared package thr_pkg SHALL hold:
  - the default W and N constants;
  - the FSM state enum typedef;
  - the signed word typedef thr_word_t.
REQ-026 One sub-module, shreg_in (parametrised W-bit MSB-first shift register with clear), SHALL be instantiated; the FSM, counters and storage stay in thr_loader.

Verification
REQ-027 Single word: W=12, N=1, after reset, shift 12'sb011001011101 MSB first.
  - soglia[0]=12'h65D one cycle after the 12th bit.
  - word_done and frame_done each pulse once; soglia_valid=1.
REQ-028 Full frame: N=4, words 12'h65D, 12'h9A2, 12'h000, 12'h7FF back to back.
  - All four registers match; soglia_valid=4'hF.
  - frame_done pulses only with the 4th word; ch=0 afterwards.
REQ-029 Abort: enable drops after 5 bits of the channel-1 word.
  - frame_err pulses once and soglia[1] is unchanged.
  - The next full word lands in channel 0.
REQ-030 Gap: 3 idle cycles between words 0 and 1; no frame_err, and word 1 lands in channel 1.
REQ-031 Reset mid-word: rst pulsed after bit 7 (asynchronously, mid-cycle).
  - All outputs are zero within the same cycle.
  - A subsequent word 12'h123 lands in channel 0.
REQ-032 THR_PARITY_EN only: word 12'h65D with parity bit 0 (wrong; correct is 1).
  - parity_err pulses and soglia[0] is unchanged.
  - Resending with parity bit 1 commits 12'h65D.
